// File: rtl/el2_btb_wr_sched.sv
// Write-port scheduler for the BTB/BHT array: arbitrates invalidate scrub, EXU and DEC
// updates onto one registered write port that stalls whenever fetch is reading.
module el2_btb_wr_sched #(
  parameter int IDX_W   = 8,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int AGE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_active,
  input  logic              scrub_req,
  output logic              scrub_busy,
  input  logic              exu_vld,
  output logic              exu_rdy,
  input  logic [IDX_W-1:0]  exu_idx,
  input  logic [TAG_W-1:0]  exu_tag,
  input  logic [DATA_W-1:0] exu_data,
  input  logic              dec_vld,
  output logic              dec_rdy,
  input  logic [IDX_W-1:0]  dec_idx,
  input  logic [TAG_W-1:0]  dec_tag,
  input  logic [DATA_W-1:0] dec_data,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [TAG_W-1:0]  wr_tag,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        wr_src
);

  localparam int AGE_W = $clog2(AGE_MAX + 1);

  localparam logic [1:0] SRC_NONE  = 2'b00;
  localparam logic [1:0] SRC_EXU   = 2'b01;
  localparam logic [1:0] SRC_DEC   = 2'b10;
  localparam logic [1:0] SRC_SCRUB = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SCRUB = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [AGE_W-1:0] age;

  logic issue_ok;
  logic dec_force;
  logic scrub_step;
  logic scrub_last;
  logic age_sat;

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    // A scrub request claims the cycle it arrives in, ahead of any update.
    issue_ok   = !rst && (state == ST_IDLE) && !rd_active && !scrub_req;
    age_sat    = (age == AGE_W'(AGE_MAX));
    dec_force  = dec_vld && age_sat;
    exu_rdy    = issue_ok && exu_vld && !dec_force;
    dec_rdy    = issue_ok && dec_vld && !exu_rdy;
    scrub_step = (state == ST_SCRUB) && !rd_active;
    scrub_last = (ptr == {IDX_W{1'b1}});
  end

  assign scrub_busy = (state == ST_SCRUB);

  // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      age     <= '0;
      wr_en   <= 1'b0;
      wr_idx  <= '0;
      wr_tag  <= '0;
      wr_data <= '0;
      wr_src  <= SRC_NONE;
    end else begin
      wr_en   <= 1'b0;
      wr_idx  <= '0;
      wr_tag  <= '0;
      wr_data <= '0;
      wr_src  <= SRC_NONE;

      // Age counts EXU wins only while DEC is actually waiting.
      if (!dec_vld || dec_rdy) begin
        age <= '0;
      end else if (exu_rdy && !age_sat) begin
        age <= age + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (scrub_req) begin
            state <= ST_SCRUB;
          end else if (exu_rdy) begin
            wr_en   <= 1'b1;
            wr_idx  <= exu_idx;
            wr_tag  <= exu_tag;
            wr_data <= exu_data;
            wr_src  <= SRC_EXU;
          end else if (dec_rdy) begin
            wr_en   <= 1'b1;
            wr_idx  <= dec_idx;
            wr_tag  <= dec_tag;
            wr_data <= dec_data;
            wr_src  <= SRC_DEC;
          end
        end
        ST_SCRUB: begin
          if (scrub_step) begin
            wr_en  <= 1'b1;
            wr_idx <= ptr;
            wr_src <= SRC_SCRUB;
            ptr    <= ptr + 1'b1;
            if (scrub_last) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_el2_btb_wr_sched.sv
// Bench for el2_btb_wr_sched: directed vector table, scrub corner sequences and
// constrained-random traffic, all checked against a cycle-level behavioural model.
module tb_el2_btb_wr_sched;

  localparam int IDX_W   = 4;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int AGE_MAX = 4;
  localparam int N_ENT   = 1 << IDX_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_active;
  logic              scrub_req;
  logic              scrub_busy;
  logic              exu_vld;
  logic              exu_rdy;
  logic [IDX_W-1:0]  exu_idx;
  logic [TAG_W-1:0]  exu_tag;
  logic [DATA_W-1:0] exu_data;
  logic              dec_vld;
  logic              dec_rdy;
  logic [IDX_W-1:0]  dec_idx;
  logic [TAG_W-1:0]  dec_tag;
  logic [DATA_W-1:0] dec_data;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  wr_tag;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        wr_src;

  always #5 clk = ~clk;

  el2_btb_wr_sched #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W),
    .AGE_MAX(AGE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_active (rd_active),
    .scrub_req (scrub_req),
    .scrub_busy(scrub_busy),
    .exu_vld   (exu_vld),
    .exu_rdy   (exu_rdy),
    .exu_idx   (exu_idx),
    .exu_tag   (exu_tag),
    .exu_data  (exu_data),
    .dec_vld   (dec_vld),
    .dec_rdy   (dec_rdy),
    .dec_idx   (dec_idx),
    .dec_tag   (dec_tag),
    .dec_data  (dec_data),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_tag    (wr_tag),
    .wr_data   (wr_data),
    .wr_src    (wr_src)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: scrub mode flag, next entry to clear, EXU wins while DEC waits.
  bit m_scrub;
  int m_ptr;
  int m_age;
  bit obs_exu_rdy;
  bit obs_dec_rdy;

  typedef struct {
    bit         rd;
    bit         ev;
    bit         dv;
    logic [3:0] eidx;
    logic [1:0] src;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs must already be driven (posedge+1). Checks rdy mid-cycle and the write after the edge.
  task automatic step(input string tag);
    bit                eg, dg, n_en, nxt_scrub;
    logic [1:0]        n_src;
    logic [IDX_W-1:0]  n_idx;
    logic [TAG_W-1:0]  n_tag;
    logic [DATA_W-1:0] n_data;
    int                nxt_ptr, nxt_age;
    eg = 0; dg = 0; n_en = 0; n_src = 2'b00;
    n_idx = '0; n_tag = '0; n_data = '0;
    nxt_scrub = m_scrub; nxt_ptr = m_ptr; nxt_age = m_age;
    if (rst) begin
      nxt_scrub = 0; nxt_ptr = 0; nxt_age = 0;
    end else begin
      if (!m_scrub) begin
        if (scrub_req) nxt_scrub = 1;
        else if (!rd_active) begin
          if (exu_vld && !(dec_vld && m_age == AGE_MAX)) eg = 1;
          else if (dec_vld) dg = 1;
        end
      end else if (!rd_active) begin
        n_en = 1; n_src = 2'b11; n_idx = IDX_W'(m_ptr);
        if (m_ptr == N_ENT - 1) begin
          nxt_scrub = 0; nxt_ptr = 0;
        end else begin
          nxt_ptr = m_ptr + 1;
        end
      end
      if (eg) begin
        n_en = 1; n_src = 2'b01; n_idx = exu_idx; n_tag = exu_tag; n_data = exu_data;
      end
      if (dg) begin
        n_en = 1; n_src = 2'b10; n_idx = dec_idx; n_tag = dec_tag; n_data = dec_data;
      end
      if (!dec_vld || dg) nxt_age = 0;
      else if (eg) nxt_age = (m_age + 1 > AGE_MAX) ? AGE_MAX : m_age + 1;
    end
    @(negedge clk);
    obs_exu_rdy = exu_rdy;
    obs_dec_rdy = dec_rdy;
    check({tag, ".exu_rdy"}, 64'(exu_rdy), 64'(eg));
    check({tag, ".dec_rdy"}, 64'(dec_rdy), 64'(dg));
    @(posedge clk);
    #1;
    check({tag, ".wr_en"}, 64'(wr_en), 64'(n_en));
    check({tag, ".wr_src"}, 64'(wr_src), 64'(n_src));
    if (n_en) begin
      check({tag, ".wr_idx"}, 64'(wr_idx), 64'(n_idx));
      check({tag, ".wr_tag"}, 64'(wr_tag), 64'(n_tag));
      check({tag, ".wr_data"}, 64'(wr_data), 64'(n_data));
    end
    check({tag, ".scrub_busy"}, 64'(scrub_busy), 64'(nxt_scrub));
    m_scrub = nxt_scrub;
    m_ptr   = nxt_ptr;
    m_age   = nxt_age;
  endtask

  initial begin
    int writes, busy, first;
    bit ep, dp;

    rst = 1'b1; rd_active = 1'b0; scrub_req = 1'b0;
    exu_vld = 1'b0; exu_idx = '0; exu_tag = '0; exu_data = '0;
    dec_vld = 1'b0; dec_idx = '0; dec_tag = '0; dec_data = '0;
    m_scrub = 0; m_ptr = 0; m_age = 0;
    @(posedge clk);
    #1;
    step("reset");
    check("reset.wr_idx", 64'(wr_idx), 64'd0);
    check("reset.wr_data", 64'(wr_data), 64'd0);
    rst = 1'b0;

    // Directed table: single EXU, sustained contention, read-blocked cycles, DEC alone.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 4'hC, 2'b01};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 4'h1, 2'b01};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 4'h2, 2'b01};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 4'h3, 2'b01};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 4'h4, 2'b01};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 4'h6, 2'b10};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 4'h6, 2'b01};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 4'h7, 2'b00};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'h7, 2'b00};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 4'h7, 2'b00};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 4'h7, 2'b01};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 4'h0, 2'b10};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 4'hA, 2'b01};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 4'h0, 2'b00};
    dec_idx = 4'h5; dec_tag = 5'h15; dec_data = 32'hBEEF_0005;
    for (int i = 0; i < 14; i++) begin
      rd_active = tbl[i].rd;
      exu_vld   = tbl[i].ev;
      dec_vld   = tbl[i].dv;
      exu_idx   = tbl[i].eidx;
      exu_tag   = TAG_W'(i);
      exu_data  = {16'hDEAD, 12'h000, tbl[i].eidx};
      step($sformatf("vec%0d", i));
      check($sformatf("vec%0d.src", i), 64'(wr_src), 64'(tbl[i].src));
      check($sformatf("vec%0d.exu_rdy", i), 64'(obs_exu_rdy), 64'(tbl[i].src == 2'b01));
      if (tbl[i].src == 2'b01)
        check($sformatf("vec%0d.data", i), 64'(wr_data), 64'({16'hDEAD, 12'h000, tbl[i].eidx}));
    end

    // Full scrub with no reads while EXU waits: 16 writes, then EXU on cycle 17.
    exu_vld = 1'b0; dec_vld = 1'b0; rd_active = 1'b0;
    scrub_req = 1'b1;
    step("s4.req");
    busy = scrub_busy ? 1 : 0;
    scrub_req = 1'b0;
    exu_vld = 1'b1; exu_idx = 4'h9; exu_tag = 5'h3; exu_data = 32'h1234_5678;
    writes = 0; first = -1;
    for (int c = 1; c <= 17; c++) begin
      step("s4");
      if (obs_exu_rdy && first < 0) first = c;
      if (scrub_busy) busy++;
      if (wr_src == 2'b11) begin
        check("s4.idx", 64'(wr_idx), 64'(writes));
        check("s4.data", 64'(wr_data), 64'd0);
        writes++;
      end
    end
    check("s4.first_exu_cycle", 64'(first), 64'd17);
    check("s4.writes", 64'(writes), 64'd16);
    check("s4.busy_cycles", 64'(busy), 64'd16);
    exu_vld = 1'b0;

    // Scrub with reads every other cycle: pointer holds, no index skipped or repeated.
    scrub_req = 1'b1;
    step("s5.req");
    scrub_req = 1'b0;
    writes = 0;
    for (int c = 0; c < 40; c++) begin
      rd_active = (c % 2 == 1);
      step("s5");
      if (wr_src == 2'b11) begin
        check("s5.idx", 64'(wr_idx), 64'(writes));
        writes++;
      end
    end
    rd_active = 1'b0;
    check("s5.writes", 64'(writes), 64'd16);
    check("s5.done", 64'(scrub_busy), 64'd0);

    // Reset while the pointer sits at 7, then a fresh scrub starts from 0.
    scrub_req = 1'b1;
    step("s6.req");
    scrub_req = 1'b0;
    repeat (7) step("s6.walk");
    check("s6.last_idx", 64'(wr_idx), 64'd6);
    rst = 1'b1;
    step("s6.rst");
    check("s6.rst_wr_en", 64'(wr_en), 64'd0);
    check("s6.rst_busy", 64'(scrub_busy), 64'd0);
    rst = 1'b0;
    scrub_req = 1'b1;
    step("s6.req2");
    scrub_req = 1'b0;
    step("s6.first");
    check("s6.restart_en", 64'(wr_en), 64'd1);
    check("s6.restart_src", 64'(wr_src), 64'd3);
    check("s6.restart_idx", 64'(wr_idx), 64'd0);
    repeat (16) step("s6.finish");

    // Random traffic: requesters hold fields until accepted.
    ep = 0; dp = 0;
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      if (!ep && $urandom_range(0, 1) == 1) begin
        ep = 1;
        exu_idx = IDX_W'($urandom); exu_tag = TAG_W'($urandom); exu_data = $urandom;
      end
      if (!dp && $urandom_range(0, 1) == 1) begin
        dp = 1;
        dec_idx = IDX_W'($urandom); dec_tag = TAG_W'($urandom); dec_data = $urandom;
      end
      exu_vld   = ep;
      dec_vld   = dp;
      rd_active = ($urandom_range(0, 9) < 3);
      scrub_req = ($urandom_range(0, 79) == 0);
      step("rand");
      if (obs_exu_rdy) ep = 0;
      if (obs_dec_rdy) dp = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
